// File: rtl/wb_trace_display.sv
// Writeback trace buffer: captures register-file writebacks into a DEPTH-entry ring
// and scans the valid entries, oldest first, onto an LED bank at a programmable rate.
module wb_trace_display #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 8,
    parameter  int LED_W    = 8,
    parameter  int SCAN_DIV = 400000000,
    localparam int AW       = $clog2(DEPTH),
    localparam int NSL      = DATA_W / LED_W,
    localparam int BW       = (NSL > 1) ? $clog2(NSL) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [4:0]        wr_rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mode,
    input  logic              freeze,
    input  logic              clear,
    input  logic [BW-1:0]     byte_sel,
    output logic [LED_W-1:0]  led,
    output logic [AW-1:0]     entry_idx,
    output logic [AW:0]       count,
    output logic              full,
    output logic              overflow
);

    localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [AW:0]    COUNT_MAX = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    disp_off_q, disp_off_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [AW-1:0]    entry_idx_q, entry_idx_d;
    logic             overflow_q, overflow_d;

    logic              capture;
    logic              full_w;
    logic              div_wrap;
    logic              mem_we;
    logic [AW-1:0]     oldest;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic [AW:0]       off_inc;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        disp_off_d  = disp_off_q;
        div_d       = div_q;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;

        capture  = wr_en && (wr_rd != 5'd0) && !freeze && !clear;
        full_w   = (count_q == COUNT_MAX);
        div_wrap = (div_q == DIV_LAST);

        // Count of DEPTH has all-zero low bits, so oldest == wr_ptr when full.
        oldest  = wr_ptr_q - count_q[AW-1:0];
        rd_idx  = oldest + disp_off_q;
        rd_word = mem_q[rd_idx];
        off_inc = (AW+1)'(disp_off_q) + (AW+1)'(1);

        led_d       = (count_q == '0) ? '0 : LED_W'(rd_word >> (LED_W * int'(byte_sel)));
        entry_idx_d = clear ? '0 : disp_off_q;

        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (count_q == '0) begin
            disp_off_d = '0;
        end else if (div_wrap) begin
            disp_off_d = (off_inc == count_q) ? '0 : off_inc[AW-1:0];
        end

        if (capture) begin
            if (!full_w) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + (AW+1)'(1);
            end else begin
                overflow_d = 1'b1;
                if (!mode) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end
        end

        if (clear) begin
            wr_ptr_d   = '0;
            count_d    = '0;
            disp_off_d = '0;
            div_d      = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            disp_off_q  <= '0;
            div_q       <= '0;
            led_q       <= '0;
            entry_idx_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values of the others.
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            disp_off_q  <= disp_off_d;
            div_q       <= div_d;
            led_q       <= led_d;
            entry_idx_q <= entry_idx_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never shown.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign led       = led_q;
    assign entry_idx = entry_idx_q;
    assign count     = count_q;
    assign full      = full_w;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wb_trace_display.sv
// Self-checking bench for wb_trace_display: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the trace buffer.
module tb_wb_trace_display;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4;
    localparam int LED_W    = 8;
    localparam int SCAN_DIV = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        mode;
    logic        freeze;
    logic        clear;
    logic [1:0]  byte_sel;
    logic [7:0]  led;
    logic [1:0]  entry_idx;
    logic [2:0]  count;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    wb_trace_display #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LED_W(LED_W), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .mode(mode), .freeze(freeze), .clear(clear), .byte_sel(byte_sel),
        .led(led), .entry_idx(entry_idx), .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: valid entries held oldest-first in a queue.
    logic [31:0] mq[$];
    int          m_off;
    int          m_div;
    bit          m_ovf;
    logic [7:0]  m_led;
    logic [1:0]  m_eidx;
    int          m_n;
    bit          m_wrap;
    logic [31:0] m_shown;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_off  = 0;
            m_div  = 0;
            m_ovf  = 1'b0;
            m_led  = 8'h00;
            m_eidx = 2'd0;
        end else begin
            m_n     = mq.size();
            m_shown = (m_n == 0) ? 32'h0 : mq[m_off];
            m_led   = (m_n == 0) ? 8'h00 : 8'(m_shown >> (8 * int'(byte_sel)));
            m_eidx  = clear ? 2'd0 : 2'(m_off);
            if (clear) begin
                mq.delete();
                m_off = 0;
                m_div = 0;
                m_ovf = 1'b0;
            end else begin
                m_wrap = (m_div == SCAN_DIV - 1);
                m_div  = m_wrap ? 0 : m_div + 1;
                if (m_n == 0)   m_off = 0;
                else if (m_wrap) m_off = (m_off + 1) % m_n;
                if (wr_en && wr_rd != 5'd0 && !freeze) begin
                    if (m_n < DEPTH) begin
                        mq.push_back(wr_data);
                    end else begin
                        m_ovf = 1'b1;
                        if (!mode) begin
                            void'(mq.pop_front());
                            mq.push_back(wr_data);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [4:0] rd, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_rd   = rd;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (led !== 8'h00)      begin bad++; $display("FAIL reset_led got=%h exp=00", led); end
        total++; if (entry_idx !== 2'd0) begin bad++; $display("FAIL reset_eidx got=%0d exp=0", entry_idx); end
        total++; if (count !== 3'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    endtask

    // Scans 12 cycles and checks that each entry_idx shows the expected value.
    task automatic scan_check(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        logic [7:0] seen [4];
        logic [7:0] exp_v [4];
        exp_v[0] = e0[7:0]; exp_v[1] = e1[7:0]; exp_v[2] = e2[7:0]; exp_v[3] = e3[7:0];
        for (int i = 0; i < 4; i++) seen[i] = 8'hxx;
        for (int c = 0; c < 12; c++) begin
            step();
            seen[entry_idx] = led;
            total++;
            if (led !== m_led) begin
                bad++; $display("FAIL %s_led_cyc%0d got=%h exp=%h", name, c, led, m_led);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seen[i] !== exp_v[i]) begin
                bad++; $display("FAIL %s_entry%0d got=%h exp=%h", name, i, seen[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_mode0();
        mode = 1'b0;
        for (int i = 1; i <= 5; i++) write_one(5'(i), 32'(i * 10));
        total++; if (count !== 3'd4)    begin bad++; $display("FAIL m0_count got=%0d exp=4", count); end
        total++; if (full !== 1'b1)     begin bad++; $display("FAIL m0_full got=%b exp=1", full); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL m0_ovf got=%b exp=1", overflow); end
        step();
        scan_check("m0", 32'd20, 32'd30, 32'd40, 32'd50);
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b1;
        #1;
        total++; if (led !== 8'h00)      begin bad++; $display("FAIL areset_led got=%h exp=00", led); end
        total++; if (count !== 3'd0)     begin bad++; $display("FAIL areset_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL areset_full got=%b exp=0", full); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL areset_ovf got=%b exp=0", overflow); end
        total++; if (entry_idx !== 2'd0) begin bad++; $display("FAIL areset_eidx got=%0d exp=0", entry_idx); end
        step();
        reset = 1'b0;
        step();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL areset_after_count got=%0d exp=0", count); end
    endtask

    task automatic test_mode1();
        mode = 1'b1;
        for (int i = 1; i <= 5; i++) write_one(5'(i), 32'(i * 10));
        total++; if (count !== 3'd4)    begin bad++; $display("FAIL m1_count got=%0d exp=4", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL m1_ovf got=%b exp=1", overflow); end
        step();
        scan_check("m1", 32'd10, 32'd20, 32'd30, 32'd40);
        write_one(5'd6, 32'd60);
        step();
        scan_check("m1_drop", 32'd10, 32'd20, 32'd30, 32'd40);
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL m1_clear_ovf got=%b exp=0", overflow); end
        total++; if (count !== 3'd0)    begin bad++; $display("FAIL m1_clear_count got=%0d exp=0", count); end
    endtask

    task automatic test_x0_freeze();
        write_one(5'd0, 32'd99);
        freeze = 1'b1;
        write_one(5'd3, 32'd77);
        freeze = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            total++; if (count !== 3'd0) begin bad++; $display("FAIL x0f_count_cyc%0d got=%0d exp=0", c, count); end
            total++; if (led !== 8'h00)  begin bad++; $display("FAIL x0f_led_cyc%0d got=%h exp=00", c, led); end
            step();
        end
    endtask

    task automatic test_clear_collision();
        mode = 1'b0;
        write_one(5'd1, 32'h11);
        write_one(5'd2, 32'h22);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL clr_pre_count got=%0d exp=2", count); end
        repeat (4) step();
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_rd   = 5'd4;
        wr_data = 32'h55;
        step();
        clear = 1'b0;
        wr_en = 1'b0;
        total++; if (count !== 3'd0)     begin bad++; $display("FAIL clr_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
        total++; if (entry_idx !== 2'd0) begin bad++; $display("FAIL clr_eidx got=%0d exp=0", entry_idx); end
        step();
        total++; if (led !== 8'h00) begin bad++; $display("FAIL clr_led got=%h exp=00", led); end
    endtask

    task automatic test_byte_sel();
        byte_sel = 2'd0;
        write_one(5'd1, 32'h0000AB7D);
        step();
        total++; if (led !== 8'h7D) begin bad++; $display("FAIL bsel0 got=%h exp=7d", led); end
        byte_sel = 2'd1;
        step();
        total++; if (led !== 8'hAB) begin bad++; $display("FAIL bsel1 got=%h exp=ab", led); end
        byte_sel = 2'd3;
        step();
        total++; if (led !== 8'h00) begin bad++; $display("FAIL bsel3 got=%h exp=00", led); end
        byte_sel = 2'd0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en    = ($urandom_range(0, 9) < 6);
            wr_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wr_data  = $urandom;
            freeze   = ($urandom_range(0, 9) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            byte_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            step();
            total++; if (led !== m_led)   begin bad++; $display("FAIL rnd_led cyc=%0d got=%h exp=%h", c, led, m_led); end
            total++; if (entry_idx !== m_eidx) begin bad++; $display("FAIL rnd_eidx cyc=%0d got=%0d exp=%0d", c, entry_idx, m_eidx); end
            total++; if (count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, mq.size()); end
            total++; if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", c, full, mq.size() == DEPTH); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
        end
        wr_en  = 1'b0;
        freeze = 1'b0;
        clear  = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_rd    = 5'd0;
        wr_data  = 32'h0;
        mode     = 1'b0;
        freeze   = 1'b0;
        clear    = 1'b0;
        byte_sel = 2'd0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_mode0();
        test_async_reset();
        test_mode1();
        test_x0_freeze();
        test_clear_collision();
        clear = 1'b1; step(); clear = 1'b0;
        test_byte_sel();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
